register_status_table: RTL and testbench
========================================

Name: register_status_table

Overview:
Parametrised register status table for the Tomasulo core. It holds one producer tag (Qi) and one value per architectural register. It records the reservation-station tag on issue and captures results broadcast on the CDB. Two combinational source-read ports feed the dispatch module, and a flush clears all pending producers after a misspeculation or trap.

Parameters:
NUM_REGS, 8, number of architectural registers (≥2)
TAG_W, 3, reservation-station tag width; tag 0 = FREE (no producer)
DATA_W, 16, register data width
IDX_W, $clog2(NUM_REGS), register index width (derived, not overridden)

Ports:
Clock  in  1  system clock, rising edge
Resetn  in  1  asynchronous active-low reset
Issue_valid  in  1  issue strobe: register Issue_rd will be produced by Issue_tag
Issue_rd  in  IDX_W  destination register of issued instruction
Issue_tag  in  TAG_W  producing reservation station
Cdb_valid  in  1  CDB broadcast strobe
Cdb_tag  in  TAG_W  tag of broadcasting station
Cdb_data  in  DATA_W  broadcast result
Flush  in  1  clear all pending producers
Src_a_idx  in  IDX_W  read port A index
Src_b_idx  in  IDX_W  read port B index
Src_a_qi  out  TAG_W  producer tag of Src_a_idx (0 = value valid)
Src_a_data  out  DATA_W  value of Src_a_idx
Src_b_qi  out  TAG_W  as port A
Src_b_data  out  DATA_W  as port A
Busy_count  out  IDX_W+1  registered count of registers with Qi≠0
Issue_err  out  1  one-cycle pulse: Issue_valid with Issue_tag==0 (issue dropped)

Behaviour:
- Resetn low (async): every Qi=0, every data=0, Busy_count=0, Issue_err=0. Reset mid-operation discards all pending tags; the first edge after release behaves as normal.
- All state updates on rising Clock. Reads are combinational, with zero-latency reads of current state.
- CDB capture: if Cdb_valid and Cdb_tag≠0, every register i with Qi[i]==Cdb_tag gets data[i]<=Cdb_data and Qi[i]<=0. Multiple registers may match in the same cycle. Cdb_tag==0 is ignored.
- Issue: if Issue_valid and Issue_tag≠0, Qi[Issue_rd]<=Issue_tag. Data is unchanged.
- Issue_tag==0 with Issue_valid: no state change; Issue_err=1 on the next cycle for one cycle.
- Same register hit by CDB match and issue in the same cycle: data[rd]<=Cdb_data AND Qi[rd]<=Issue_tag. Issue wins on Qi.
- Issue_tag equal to Cdb_tag in the same cycle: CDB applies to the old matches, and the issued register keeps the new tag.
- Flush: all Qi<=0, data untouched. It has priority over issue and CDB on Qi. A CDB data write in the same cycle still lands on matching registers.
- Busy_count updates on the same edge as Qi and equals popcount(Qi≠0) of the new state. The range is 0..NUM_REGS with no wrap.
- Read ports are independent. Src_a_idx==Src_b_idx is legal and both ports return identical values.
- Out-of-range index (≥NUM_REGS, non-power-of-2 NUM_REGS): read returns qi=0, data=0. An issue to such an index is dropped silently.

Optional Feature:
REG_STATUS_CDB_BYPASS_EN
- Defined: for each read port, if Cdb_valid, Cdb_tag≠0 and Qi[src]==Cdb_tag, the port returns qi=0 and data=Cdb_data in the same cycle. This removes one cycle of dispatch stall.
- Undefined: read ports reflect registered state only, so the value appears the cycle after the broadcast.

Decomposition:
- Package reg_status_pkg holds:
  - FREE_TAG = 0.
  - The no-value constant 16'hFFF0, used by the dispatch module.
  - Default TAG_W/DATA_W localparams.
- One natural sub-module, reg_status_entry, covers a single register's Qi/data flops with the CDB-match, issue, flush and priority logic. It is instantiated NUM_REGS times by generate.
- Read muxing, bypass and Busy_count popcount stay in the top.

Test Plan:
- Reset: Resetn=0 mid-run with R3 busy → Src_a (idx 3) qi=0 data=0, Busy_count=0 immediately, without waiting for a clock edge.
- Issue R2 tag 1, then CDB tag 1 data 16'h00AB two cycles later → R2 qi=1 and Busy_count=1 in between. After the CDB edge, R2 qi=0, data=00AB, Busy_count=0.
- Issue R1 and R4 with tag 2, then a single CDB tag 2 data 16'h1234 → both registers get data 1234 and qi=0 on the same edge.
- Same-cycle CDB tag 1 data 16'h0055 and issue R2 tag 2, with R2 previously tag 1 → R2 data=0055, qi=2, Busy_count unchanged.
- Flush with R0..R7 busy and a simultaneous issue R5 tag 3 → all qi=0, Busy_count=0, data unchanged.
- Issue tag 0 to R6 → R6 unchanged and Issue_err high for exactly one cycle. With the bypass macro defined, a read of a busy register during a matching CDB returns qi=0 and Cdb_data in that cycle; without the macro, it returns the old tag.

Source files
------------

// File: rtl/register_status_table_pkg.sv
// Shared constants for the register status table (package reg_status_pkg).
package reg_status_pkg;

  // Tag value meaning "no pending producer": the register value is valid.
  localparam int unsigned FREE_TAG = 0;

  // Operand value the dispatch module substitutes when no value is available.
  localparam logic [15:0] NO_VALUE = 16'hFFF0;

  localparam int DEFAULT_TAG_W  = 3;
  localparam int DEFAULT_DATA_W = 16;

endpackage

// File: rtl/register_status_table_entry.sv
// One architectural register: producer tag (Qi) and value, with CDB capture,
// issue and flush. On Qi, flush beats issue, and issue beats a CDB match.
// A CDB match always writes the data, even during a flush or an issue.
module reg_status_entry
  import reg_status_pkg::*;
#(
  parameter int TAG_W  = DEFAULT_TAG_W,
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              cdb_valid_i,
  input  logic [TAG_W-1:0]  cdb_tag_i,
  input  logic [DATA_W-1:0] cdb_data_i,
  input  logic              issue_we_i,
  input  logic [TAG_W-1:0]  issue_tag_i,
  input  logic              flush_i,
  output logic [TAG_W-1:0]  qi_o,
  output logic [TAG_W-1:0]  qi_next_o,
  output logic [DATA_W-1:0] data_o
);

  logic [TAG_W-1:0]  qi_q, qi_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              cdb_hit;

  // Next state: a CDB match captures the data; Qi is chosen by priority.
  always_comb begin
    cdb_hit = cdb_valid_i && (cdb_tag_i != TAG_W'(FREE_TAG)) && (qi_q == cdb_tag_i);
    data_d  = cdb_hit ? cdb_data_i : data_q;
    qi_d    = qi_q;
    if (flush_i)         qi_d = TAG_W'(FREE_TAG);
    else if (issue_we_i) qi_d = issue_tag_i;
    else if (cdb_hit)    qi_d = TAG_W'(FREE_TAG);
  end

  // State registers, cleared by async reset.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      qi_q   <= '0;
      data_q <= '0;
    end else begin
      qi_q   <= qi_d;
      data_q <= data_d;
    end
  end

  assign qi_o      = qi_q;
  assign qi_next_o = qi_d;
  assign data_o    = data_q;

endmodule

// File: rtl/register_status_table.sv
// Register status table: per-register producer tag and value, two
// combinational read ports, registered busy count and issue error pulse.
// Optional macro REG_STATUS_CDB_BYPASS_EN forwards a matching CDB broadcast
// straight to the read ports in the same cycle.
module register_status_table
  import reg_status_pkg::*;
#(
  parameter  int NUM_REGS = 8,
  parameter  int TAG_W    = DEFAULT_TAG_W,
  parameter  int DATA_W   = DEFAULT_DATA_W,
  localparam int IDX_W    = $clog2(NUM_REGS)
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              Issue_valid,
  input  logic [IDX_W-1:0]  Issue_rd,
  input  logic [TAG_W-1:0]  Issue_tag,
  input  logic              Cdb_valid,
  input  logic [TAG_W-1:0]  Cdb_tag,
  input  logic [DATA_W-1:0] Cdb_data,
  input  logic              Flush,
  input  logic [IDX_W-1:0]  Src_a_idx,
  input  logic [IDX_W-1:0]  Src_b_idx,
  output logic [TAG_W-1:0]  Src_a_qi,
  output logic [DATA_W-1:0] Src_a_data,
  output logic [TAG_W-1:0]  Src_b_qi,
  output logic [DATA_W-1:0] Src_b_data,
  output logic [IDX_W:0]    Busy_count,
  output logic              Issue_err
);

  localparam int NUM_SLOTS = 1 << IDX_W;
  localparam int CNT_W     = IDX_W + 1;

  // Slots beyond NUM_REGS read as qi=0/data=0 so out-of-range reads need no guard.
  logic [TAG_W-1:0]  qi_arr   [NUM_SLOTS];
  logic [DATA_W-1:0] data_arr [NUM_SLOTS];
  logic [TAG_W-1:0]  qi_nxt   [NUM_REGS];

  logic             issue_ok;
  logic [CNT_W-1:0] busy_q, busy_d;
  logic             issue_err_q, issue_err_d;

  assign issue_ok = Issue_valid && (Issue_tag != TAG_W'(FREE_TAG));

  for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
    if (i < NUM_REGS) begin : g_entry
      reg_status_entry #(
        .TAG_W  (TAG_W),
        .DATA_W (DATA_W)
      ) u_entry (
        .clk_i       (Clock),
        .rst_n_i     (Resetn),
        .cdb_valid_i (Cdb_valid),
        .cdb_tag_i   (Cdb_tag),
        .cdb_data_i  (Cdb_data),
        .issue_we_i  (issue_ok && (Issue_rd == IDX_W'(i))),
        .issue_tag_i (Issue_tag),
        .flush_i     (Flush),
        .qi_o        (qi_arr[i]),
        .qi_next_o   (qi_nxt[i]),
        .data_o      (data_arr[i])
      );
    end else begin : g_empty
      assign qi_arr[i]   = '0;
      assign data_arr[i] = '0;
    end
  end

  // Busy count tracks the post-edge Qi state, so count the next-state tags.
  always_comb begin
    busy_d = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (qi_nxt[i] != TAG_W'(FREE_TAG)) busy_d = busy_d + CNT_W'(1);
    end
    issue_err_d = Issue_valid && (Issue_tag == TAG_W'(FREE_TAG));
  end

  // Registered status outputs.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      busy_q      <= '0;
      issue_err_q <= 1'b0;
    end else begin
      busy_q      <= busy_d;
      issue_err_q <= issue_err_d;
    end
  end

  assign Busy_count = busy_q;
  assign Issue_err  = issue_err_q;

  // Read ports: current state, optionally overridden by a matching CDB broadcast.
  always_comb begin
    Src_a_qi   = qi_arr[Src_a_idx];
    Src_a_data = data_arr[Src_a_idx];
    Src_b_qi   = qi_arr[Src_b_idx];
    Src_b_data = data_arr[Src_b_idx];
`ifdef REG_STATUS_CDB_BYPASS_EN
    if (Cdb_valid && (Cdb_tag != TAG_W'(FREE_TAG))) begin
      if (qi_arr[Src_a_idx] == Cdb_tag) begin
        Src_a_qi   = '0;
        Src_a_data = Cdb_data;
      end
      if (qi_arr[Src_b_idx] == Cdb_tag) begin
        Src_b_qi   = '0;
        Src_b_data = Cdb_data;
      end
    end
`endif
  end

endmodule

// File: tb/tb_register_status_table.sv
// Self-checking bench for register_status_table (default parameters).
module tb_register_status_table;

  localparam int NUM_REGS = 8;
  localparam int TAG_W    = 3;
  localparam int DATA_W   = 16;
  localparam int IDX_W    = 3;

  logic              Clock = 1'b0;
  logic              Resetn;
  logic              Issue_valid;
  logic [IDX_W-1:0]  Issue_rd;
  logic [TAG_W-1:0]  Issue_tag;
  logic              Cdb_valid;
  logic [TAG_W-1:0]  Cdb_tag;
  logic [DATA_W-1:0] Cdb_data;
  logic              Flush;
  logic [IDX_W-1:0]  Src_a_idx, Src_b_idx;
  logic [TAG_W-1:0]  Src_a_qi, Src_b_qi;
  logic [DATA_W-1:0] Src_a_data, Src_b_data;
  logic [IDX_W:0]    Busy_count;
  logic              Issue_err;

  int n_tests = 0;
  int n_fail  = 0;

  register_status_table #(.NUM_REGS(NUM_REGS), .TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
    .Clock(Clock), .Resetn(Resetn),
    .Issue_valid(Issue_valid), .Issue_rd(Issue_rd), .Issue_tag(Issue_tag),
    .Cdb_valid(Cdb_valid), .Cdb_tag(Cdb_tag), .Cdb_data(Cdb_data),
    .Flush(Flush), .Src_a_idx(Src_a_idx), .Src_b_idx(Src_b_idx),
    .Src_a_qi(Src_a_qi), .Src_a_data(Src_a_data),
    .Src_b_qi(Src_b_qi), .Src_b_data(Src_b_data),
    .Busy_count(Busy_count), .Issue_err(Issue_err)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    string             name;
    logic              iv;
    logic [IDX_W-1:0]  rd;
    logic [TAG_W-1:0]  itag;
    logic              cv;
    logic [TAG_W-1:0]  ctag;
    logic [DATA_W-1:0] cdata;
    logic              fl;
    logic [IDX_W-1:0]  a_idx;
    logic [IDX_W-1:0]  b_idx;
    logic [TAG_W-1:0]  a_qi;
    logic [DATA_W-1:0] a_data;
    logic [TAG_W-1:0]  b_qi;
    logic [DATA_W-1:0] b_data;
    logic [IDX_W:0]    busy;
    logic              err;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];

  function automatic vec_t mk(string name, logic iv, int rd, int itag,
                              logic cv, int ctag, logic [15:0] cdata, logic fl,
                              int a_idx, int b_idx, int a_qi, logic [15:0] a_data,
                              int b_qi, logic [15:0] b_data, int busy, logic err);
    vec_t v;
    v.name = name; v.iv = iv; v.rd = IDX_W'(rd); v.itag = TAG_W'(itag);
    v.cv = cv; v.ctag = TAG_W'(ctag); v.cdata = cdata; v.fl = fl;
    v.a_idx = IDX_W'(a_idx); v.b_idx = IDX_W'(b_idx);
    v.a_qi = TAG_W'(a_qi); v.a_data = a_data; v.b_qi = TAG_W'(b_qi); v.b_data = b_data;
    v.busy = (IDX_W+1)'(busy); v.err = err;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    Issue_valid = 1'b0; Issue_rd = '0; Issue_tag = '0;
    Cdb_valid = 1'b0; Cdb_tag = '0; Cdb_data = '0; Flush = 1'b0;
  endtask

  task automatic compare_ports(vec_t e);
    check({e.name, ".a_qi"},   32'(Src_a_qi),   32'(e.a_qi));
    check({e.name, ".a_data"}, 32'(Src_a_data), 32'(e.a_data));
    check({e.name, ".b_qi"},   32'(Src_b_qi),   32'(e.b_qi));
    check({e.name, ".b_data"}, 32'(Src_b_data), 32'(e.b_data));
    check({e.name, ".busy"},   32'(Busy_count), 32'(e.busy));
    check({e.name, ".err"},    32'(Issue_err),  32'(e.err));
  endtask

  // Drive one vector for a single edge, then read back with strobes released.
  task automatic apply(vec_t v);
    vec_t e;
    @(negedge Clock);
    Issue_valid = v.iv; Issue_rd = v.rd; Issue_tag = v.itag;
    Cdb_valid = v.cv; Cdb_tag = v.ctag; Cdb_data = v.cdata; Flush = v.fl;
    exp_q.push_back(v);
    @(posedge Clock);
    #1;
    idle_inputs();
    Src_a_idx = v.a_idx; Src_b_idx = v.b_idx;
    #1;
    e = exp_q.pop_front();
    compare_ports(e);
  endtask

  initial begin
    idle_inputs();
    Src_a_idx = '0; Src_b_idx = 3'd7;
    Resetn = 1'b0;
    #12;
    check("rst.a_qi", 32'(Src_a_qi), 0);
    check("rst.b_data", 32'(Src_b_data), 0);
    check("rst.busy", 32'(Busy_count), 0);
    check("rst.err", 32'(Issue_err), 0);
    @(negedge Clock);
    Resetn = 1'b1;

    //            name        iv rd it cv ct cdata     fl  a  b  aqi adata     bqi bdata    busy err
    vecs.push_back(mk("iss_r2",   1, 2, 1, 0, 0, 16'h0000, 0, 2, 0, 1, 16'h0000, 0, 16'h0000, 1, 0));
    vecs.push_back(mk("hold_r2",  0, 0, 0, 0, 0, 16'h0000, 0, 2, 2, 1, 16'h0000, 1, 16'h0000, 1, 0));
    vecs.push_back(mk("cdb_r2",   0, 0, 0, 1, 1, 16'h00AB, 0, 2, 2, 0, 16'h00AB, 0, 16'h00AB, 0, 0));
    vecs.push_back(mk("iss_r1",   1, 1, 2, 0, 0, 16'h0000, 0, 1, 0, 2, 16'h0000, 0, 16'h0000, 1, 0));
    vecs.push_back(mk("iss_r4",   1, 4, 2, 0, 0, 16'h0000, 0, 1, 4, 2, 16'h0000, 2, 16'h0000, 2, 0));
    vecs.push_back(mk("cdb_multi",0, 0, 0, 1, 2, 16'h1234, 0, 1, 4, 0, 16'h1234, 0, 16'h1234, 0, 0));
    vecs.push_back(mk("iss_r2b",  1, 2, 1, 0, 0, 16'h0000, 0, 2, 1, 1, 16'h00AB, 0, 16'h1234, 1, 0));
    vecs.push_back(mk("cdb_iss",  1, 2, 2, 1, 1, 16'h0055, 0, 2, 2, 2, 16'h0055, 2, 16'h0055, 1, 0));
    vecs.push_back(mk("iss_tag0", 1, 6, 0, 0, 0, 16'h0000, 0, 6, 2, 0, 16'h0000, 2, 16'h0055, 1, 1));
    vecs.push_back(mk("err_off",  0, 0, 0, 0, 0, 16'h0000, 0, 6, 2, 0, 16'h0000, 2, 16'h0055, 1, 0));
    vecs.push_back(mk("cdb_tag0", 0, 0, 0, 1, 0, 16'hFFFF, 0, 0, 6, 0, 16'h0000, 0, 16'h0000, 1, 0));
    vecs.push_back(mk("same_tag", 1, 3, 2, 1, 2, 16'h0777, 0, 2, 3, 0, 16'h0777, 2, 16'h0000, 1, 0));
    vecs.push_back(mk("fill_r0",  1, 0, 1, 0, 0, 16'h0000, 0, 0, 3, 1, 16'h0000, 2, 16'h0000, 2, 0));
    vecs.push_back(mk("fill_r1",  1, 1, 1, 0, 0, 16'h0000, 0, 1, 0, 1, 16'h1234, 1, 16'h0000, 3, 0));
    vecs.push_back(mk("fill_r2",  1, 2, 4, 0, 0, 16'h0000, 0, 2, 1, 4, 16'h0777, 1, 16'h1234, 4, 0));
    vecs.push_back(mk("fill_r4",  1, 4, 5, 0, 0, 16'h0000, 0, 4, 2, 5, 16'h1234, 4, 16'h0777, 5, 0));
    vecs.push_back(mk("fill_r5",  1, 5, 6, 0, 0, 16'h0000, 0, 5, 4, 6, 16'h0000, 5, 16'h1234, 6, 0));
    vecs.push_back(mk("fill_r6",  1, 6, 7, 0, 0, 16'h0000, 0, 6, 5, 7, 16'h0000, 6, 16'h0000, 7, 0));
    vecs.push_back(mk("fill_r7",  1, 7, 1, 0, 0, 16'h0000, 0, 7, 6, 1, 16'h0000, 7, 16'h0000, 8, 0));
    vecs.push_back(mk("flush",    1, 5, 3, 1, 1, 16'h0999, 1, 5, 0, 0, 16'h0000, 0, 16'h0999, 0, 0));
    vecs.push_back(mk("post_fl",  0, 0, 0, 0, 0, 16'h0000, 0, 2, 7, 0, 16'h0777, 0, 16'h0999, 0, 0));
    vecs.push_back(mk("post_fl2", 0, 0, 0, 0, 0, 16'h0000, 0, 4, 1, 0, 16'h1234, 0, 16'h0999, 0, 0));

    foreach (vecs[i]) apply(vecs[i]);

    // Async reset mid-run with R3 busy: clears before any clock edge.
    apply(mk("busy_r3", 1, 3, 5, 0, 0, 16'h0000, 0, 3, 1, 5, 16'h0000, 0, 16'h0999, 1, 0));
    @(negedge Clock);
    #2;
    Resetn = 1'b0;
    #1;
    check("async_rst.a_qi", 32'(Src_a_qi), 0);
    check("async_rst.a_data", 32'(Src_a_data), 0);
    check("async_rst.b_data", 32'(Src_b_data), 0);
    check("async_rst.busy", 32'(Busy_count), 0);
    @(negedge Clock);
    Resetn = 1'b1;
    apply(mk("after_rst", 1, 1, 3, 0, 0, 16'h0000, 0, 1, 3, 3, 16'h0000, 0, 16'h0000, 1, 0));

    // Same-cycle read of a busy register during its CDB broadcast.
    @(negedge Clock);
    Cdb_valid = 1'b1; Cdb_tag = 3'd3; Cdb_data = 16'h0ABC;
    Src_a_idx = 3'd1; Src_b_idx = 3'd1;
    #1;
`ifdef REG_STATUS_CDB_BYPASS_EN
    check("bypass.a_qi", 32'(Src_a_qi), 0);
    check("bypass.a_data", 32'(Src_a_data), 32'h0ABC);
    check("bypass.b_data", 32'(Src_b_data), 32'h0ABC);
`else
    check("nobypass.a_qi", 32'(Src_a_qi), 3);
    check("nobypass.a_data", 32'(Src_a_data), 0);
    check("nobypass.b_qi", 32'(Src_b_qi), 3);
`endif
    @(posedge Clock);
    #1;
    idle_inputs();
    #1;
    check("cdb_after.a_qi", 32'(Src_a_qi), 0);
    check("cdb_after.a_data", 32'(Src_a_data), 32'h0ABC);
    check("cdb_after.busy", 32'(Busy_count), 0);

    if (exp_q.size() != 0) check("scoreboard_drain", 32'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
